perf_event_monitor: RTL and testbench

- Parametrised, synthesisable cycle and event monitor for the pipelined CPU. It moves the bench-side bookkeeping (cycle counter, stall/flush counts, stop-after-N-cycles) into RTL.
- Counts run cycles and NUM_EVT independent event lines, such as stall, flush, retire and branch.
- Supports a cycle limit, pause/resume, saturation with sticky overflow flags, and a snapshot/readback port.
- Instantiated beside CPU and driven by its start_i and hazard/control strobes.

---
 rtl/perf_event_monitor.sv | 153 +++++++++++++++
 tb/tb_perf_event_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_monitor.sv
// Cycle and event monitor for the pipelined CPU: run-cycle counter plus NUM_EVT event
// counters with cycle limit, pause/resume, saturation flags and a shadow snapshot bank.
module perf_event_monitor #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               limit_en_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               snap_valid_o,
  output logic [1:0]         state_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  // Slot 0 is the cycle counter, slot k+1 is event counter k.
  localparam int NUM_CNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               count_en;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] ovf_q;
  logic [CNT_W-1:0]   cyc_next;
  logic [CNT_W-1:0]   rd_mux;
  logic [CNT_W-1:0]   cnt_q    [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic               snap_valid_q;
  logic [CNT_W-1:0]   rd_data_q;

  assign inc      = {evt_i, 1'b1};
  assign cyc_next = (cnt_q[0] == CNT_MAX) ? cnt_q[0] : cnt_q[0] + CNT_W'(1);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (limit_en_i && (limit_i == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (limit_en_i && (cnt_q[0] > limit_i)) begin
          // Limit was lowered below the current count: stop without counting.
          state_d = ST_DONE;
        end else begin
          count_en = 1'b1;
          if (limit_en_i && (cyc_next == limit_i)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (count_en) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_q[i] <= 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // NOTE: the shadow bank is a small register array that must read zero after
  // reset, so it is reset explicitly; clear_i deliberately leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (snap_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_q[i] <= cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      snap_valid_q <= 1'b0;
    end else if (snap_i) begin
      snap_valid_q <= 1'b1;
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_mux = shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign snap_valid_o = snap_valid_q;
  assign state_o      = state_q;
  assign running_o    = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed self-checking bench for perf_event_monitor: a 32-bit instance for the main
// scenarios and a 4-bit instance sharing the same stimulus for saturation.
module tb_perf_event_monitor;

  localparam int NUM_EVT = 4;
  localparam int CNT_W   = 32;
  localparam int CNT_WS  = 4;
  localparam int SEL_W   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, clear, limit_en, snap;
  logic [NUM_EVT-1:0] evt;
  logic [CNT_W-1:0]   limit;
  logic [SEL_W-1:0]   rd_sel;

  logic [CNT_W-1:0]   rd_data;
  logic               snap_valid, running, done;
  logic [1:0]         state;
  logic [NUM_EVT:0]   ovf;

  logic [CNT_WS-1:0]  rd_data_s;
  logic               snap_valid_s, running_s, done_s;
  logic [1:0]         state_s;
  logic [NUM_EVT:0]   ovf_s;

  int checks   = 0;
  int failures = 0;

  perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_en_i(limit_en), .limit_i(limit), .snap_i(snap), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .snap_valid_o(snap_valid), .state_o(state),
    .running_o(running), .done_o(done), .ovf_o(ovf)
  );

  perf_event_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_WS), .SEL_W(SEL_W)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
    .limit_en_i(limit_en), .limit_i(limit[CNT_WS-1:0]), .snap_i(snap), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data_s), .snap_valid_o(snap_valid_s), .state_o(state_s),
    .running_o(running_s), .done_o(done_s), .ovf_o(ovf_s)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap_pulse();
    snap = 1'b1;
    step(1);
    snap = 1'b0;
  endtask

  task automatic read_sel(input int sel);
    rd_sel = SEL_W'(sel);
    step(1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; limit_en = 1'b0; snap = 1'b0;
    evt = '0; limit = '0; rd_sel = '0;
    step(2);
    rst = 1'b0;

    check("reset_state", state, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_snap_valid", snap_valid, 0);
    check("reset_ovf", ovf, 0);

    // Limit of 30 run cycles, evt[0] on every third run cycle starting with the first.
    limit_en = 1'b1;
    limit    = 30;
    start    = 1'b1;
    step(1);
    check("t1_running", running, 1);
    for (int c = 0; c < 30; c++) begin
      evt[0] = (c % 3 == 0);
      step(1);
      if (c == 28) check("t1_not_done_early", done, 0);
    end
    evt = '0;
    check("t1_done", done, 1);
    check("t1_state", state, 2);
    step(3);
    check("t1_start_ignored", state, 2);
    snap_pulse();
    check("t1_snap_valid", snap_valid, 1);
    read_sel(0);
    check("t1_cycles", rd_data, 30);
    read_sel(1);
    check("t1_evt0", rd_data, 10);
    read_sel(NUM_EVT + 1);
    check("t1_oob_sel", rd_data, 0);

    // Pause/resume with evt[1] held high: 5 counted, 4 paused edges, 5 counted.
    start = 1'b0;
    do_clear();
    check("t2_clear_state", state, 0);
    check("t2_clear_ovf", ovf, 0);
    check("t2_clear_snap_valid", snap_valid, 0);
    limit_en = 1'b0;
    evt      = 4'b0010;
    start    = 1'b1;
    step(6);
    start = 1'b0;
    step(2);
    check("t2_paused_state", state, 0);
    snap_pulse();
    read_sel(0);
    check("t2_cycles_mid_pause", rd_data, 5);
    start = 1'b1;
    step(6);
    start = 1'b0;
    step(1);
    snap_pulse();
    read_sel(0);
    check("t2_cycles", rd_data, 10);
    read_sel(2);
    check("t2_evt1", rd_data, 10);

    // Saturation on the 4-bit instance: 20 run cycles with evt[2] high.
    evt = '0;
    do_clear();
    evt   = 4'b0100;
    start = 1'b1;
    step(21);
    start = 1'b0;
    evt   = '0;
    step(1);
    check("t3_ovf_small", ovf_s, 5'b01001);
    check("t3_ovf_wide", ovf, 0);
    snap_pulse();
    read_sel(3);
    check("t3_evt2_sat", rd_data_s, 15);
    read_sel(0);
    check("t3_cycles_sat", rd_data_s, 15);
    check("t3_cycles_wide", rd_data, 20);
    do_clear();
    check("t3_clear_ovf", ovf_s, 0);
    snap_pulse();
    read_sel(3);
    check("t3_clear_evt2", rd_data_s, 0);

    // Snap and clear on the same edge after 7 counted cycles.
    do_clear();
    start = 1'b1;
    step(8);
    start = 1'b0;
    snap  = 1'b1;
    clear = 1'b1;
    step(1);
    snap  = 1'b0;
    clear = 1'b0;
    check("t4_snap_valid", snap_valid, 0);
    check("t4_state", state, 0);
    read_sel(0);
    check("t4_shadow_cycles", rd_data, 7);
    snap_pulse();
    check("t4_snap_valid_after", snap_valid, 1);
    read_sel(0);
    check("t4_live_cleared", rd_data, 0);

    // Zero limit: straight to DONE with nothing counted.
    limit_en = 1'b1;
    limit    = 0;
    evt      = 4'b1111;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    check("t5_done", state, 2);
    check("t5_not_running", running, 0);
    snap_pulse();
    read_sel(0);
    check("t5_cycles_zero", rd_data, 0);
    read_sel(1);
    check("t5_evt0_zero", rd_data, 0);
    read_sel(NUM_EVT + 1);
    check("t5_oob_sel", rd_data, 0);

    // Limit lowered mid-run below the current count.
    evt = '0;
    do_clear();
    limit = 100;
    start = 1'b1;
    step(11);
    limit = 5;
    step(1);
    check("t6_lowered_done", state, 2);
    step(2);
    snap_pulse();
    read_sel(0);
    check("t6_no_extra_count", rd_data, 10);

    // Reset mid-run after a snapshot of non-zero counters.
    start    = 1'b0;
    do_clear();
    limit_en = 1'b0;
    evt      = 4'b1111;
    start    = 1'b1;
    step(6);
    snap_pulse();
    check("t7_running", running, 1);
    check("t7_snap_valid", snap_valid, 1);
    rst = 1'b1;
    step(1);
    rst   = 1'b0;
    start = 1'b0;
    evt   = '0;
    check("t7_rst_state", state, 0);
    check("t7_rst_running", running, 0);
    check("t7_rst_snap_valid", snap_valid, 0);
    check("t7_rst_ovf", ovf, 0);
    check("t7_rst_rd_data", rd_data, 0);
    read_sel(0);
    check("t7_shadow_cycles_zero", rd_data, 0);
    read_sel(4);
    check("t7_shadow_evt3_zero", rd_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
